// File: rtl/eco32_core_fpu_wbq.sv
// FPU write-back queue: first-word-fall-through FIFO between the FPU pipeline and the
// shared register-file write port, with occupancy, issue-stall and sticky overflow reporting.
module eco32_core_fpu_wbq #(
  parameter int unsigned DEPTH_LOG2   = 3,
  parameter int unsigned STALL_MARGIN = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_stb0,
  input  logic                  i_stb1,
  input  logic [1:0]            i_enaA,
  input  logic                  i_tagA,
  input  logic [1:0]            i_enaB,
  input  logic                  i_tagB,
  input  logic                  i_modB,
  input  logic [4:0]            i_addr,
  input  logic [31:0]           i_dataL,
  input  logic [31:0]           i_dataH,
  output logic                  wb_stb0,
  output logic                  wb_stb1,
  output logic [1:0]            wb_enaA,
  output logic                  wb_tagA,
  output logic [1:0]            wb_enaB,
  output logic                  wb_tagB,
  output logic                  wb_modB,
  output logic [4:0]            wb_addr,
  output logic [31:0]           wb_dataL,
  output logic [31:0]           wb_dataH,
  input  logic                  wb_ack,
  output logic                  o_stall,
  output logic [DEPTH_LOG2:0]   o_cnt,
  output logic                  o_ovf
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned EW    = 78;

  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  // Stall once fewer than STALL_MARGIN+1 entries remain free.
  localparam logic [CW-1:0] STALL_THR = CW'(DEPTH - STALL_MARGIN - 1);

  logic [EW-1:0]         mem [DEPTH];
  logic [EW-1:0]         in_word;
  logic [EW-1:0]         head_word;

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  stall_q, stall_d;
  logic                  ovf_q, ovf_d;

  logic push, valid, pop, full, accept, drop;

  assign in_word = {i_stb0, i_stb1, i_enaA, i_tagA, i_enaB, i_tagB, i_modB,
                    i_addr, i_dataL, i_dataH};

  always_comb begin
    push   = i_stb0 | i_stb1;
    valid  = (cnt_q != '0);
    pop    = valid & wb_ack;
    full   = (cnt_q == CNT_FULL);
    // A pop frees the head slot in the same cycle, so a full queue still accepts.
    accept = push & (~full | pop);
    drop   = push & full & ~pop;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q | drop;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (accept && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !accept) begin
      cnt_d = cnt_q - 1'b1;
    end
    stall_d = (cnt_d > STALL_THR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      stall_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage holds no reset so it can map onto LUT-RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_q] <= in_word;
    end
  end

  assign head_word = valid ? mem[rd_ptr_q] : '0;

  assign {wb_stb0, wb_stb1, wb_enaA, wb_tagA, wb_enaB, wb_tagB, wb_modB,
          wb_addr, wb_dataL, wb_dataH} = head_word;

  assign o_stall = stall_q;
  assign o_cnt   = cnt_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_eco32_core_fpu_wbq.sv
// Self-checking bench for eco32_core_fpu_wbq: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_eco32_core_fpu_wbq;

  localparam int DL    = 3;
  localparam int DEPTH = 8;
  localparam int SM    = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        i_stb0 = 0, i_stb1 = 0, i_tagA = 0, i_tagB = 0, i_modB = 0, wb_ack = 0;
  logic [1:0]  i_enaA = 0, i_enaB = 0;
  logic [4:0]  i_addr = 0;
  logic [31:0] i_dataL = 0, i_dataH = 0;

  logic        wb_stb0, wb_stb1, wb_tagA, wb_tagB, wb_modB, o_stall, o_ovf;
  logic [1:0]  wb_enaA, wb_enaB;
  logic [4:0]  wb_addr;
  logic [31:0] wb_dataL, wb_dataH;
  logic [DL:0] o_cnt;

  eco32_core_fpu_wbq #(.DEPTH_LOG2(DL), .STALL_MARGIN(SM)) dut (
    .clk(clk), .rst(rst),
    .i_stb0(i_stb0), .i_stb1(i_stb1), .i_enaA(i_enaA), .i_tagA(i_tagA),
    .i_enaB(i_enaB), .i_tagB(i_tagB), .i_modB(i_modB), .i_addr(i_addr),
    .i_dataL(i_dataL), .i_dataH(i_dataH),
    .wb_stb0(wb_stb0), .wb_stb1(wb_stb1), .wb_enaA(wb_enaA), .wb_tagA(wb_tagA),
    .wb_enaB(wb_enaB), .wb_tagB(wb_tagB), .wb_modB(wb_modB), .wb_addr(wb_addr),
    .wb_dataL(wb_dataL), .wb_dataH(wb_dataH), .wb_ack(wb_ack),
    .o_stall(o_stall), .o_cnt(o_cnt), .o_ovf(o_ovf)
  );

  typedef logic [77:0] ent_t;
  ent_t in_word, out_word;
  assign in_word  = {i_stb0, i_stb1, i_enaA, i_tagA, i_enaB, i_tagB, i_modB,
                     i_addr, i_dataL, i_dataH};
  assign out_word = {wb_stb0, wb_stb1, wb_enaA, wb_tagA, wb_enaB, wb_tagB, wb_modB,
                     wb_addr, wb_dataL, wb_dataH};

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string nm, input logic [77:0] act, input logic [77:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: an unbounded queue capped at DEPTH by the acceptance rule.
  ent_t q[$];
  int   m_size  = 0;
  logic m_ovf   = 1'b0;
  logic m_stall = 1'b0;
  logic m_push, m_pop, m_acc;
  assign m_push = i_stb0 | i_stb1;
  assign m_pop  = (m_size != 0) && wb_ack;
  assign m_acc  = m_push && ((m_size < DEPTH) || m_pop);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_size  <= 0;
      m_ovf   <= 1'b0;
      m_stall <= 1'b0;
    end else begin
      if (m_pop) void'(q.pop_front());
      if (m_acc) q.push_back(in_word);
      if (m_push && !m_acc) m_ovf <= 1'b1;
      m_size  <= m_size + int'(m_acc) - int'(m_pop);
      m_stall <= (m_size + int'(m_acc) - int'(m_pop)) > (DEPTH - SM - 1);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("model_bundle", out_word, (m_size != 0) ? q[0] : '0);
      chk("model_cnt", 78'(o_cnt), 78'(m_size));
      chk("model_stall", 78'(o_stall), 78'(m_stall));
      chk("model_ovf", 78'(o_ovf), 78'(m_ovf));
    end
  end

  task automatic put(input logic s0, input logic s1, input logic [4:0] a,
                     input logic [31:0] dl, input logic [31:0] dh, input logic ack);
    i_stb0  = s0;
    i_stb1  = s1;
    i_addr  = a;
    i_dataL = dl;
    i_dataH = dh;
    i_enaA  = 2'b11;
    i_tagA  = 1'($urandom);
    i_enaB  = 2'($urandom);
    i_tagB  = 1'($urandom);
    i_modB  = 1'($urandom);
    wb_ack  = ack;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    put(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cnt", 78'(o_cnt), 78'd0);
    chk("rst_bundle", out_word, '0);
    rst = 1'b1;
    @(negedge clk);

    // Single push, hold, single ack.
    put(1'b1, 1'b1, 5'd7, 32'h3F80_0000, 32'd0, 1'b0);
    tick();
    idle();
    chk("t1_addr", 78'(wb_addr), 78'd7);
    chk("t1_dataL", 78'(wb_dataL), 78'h3F80_0000);
    chk("t1_cnt", 78'(o_cnt), 78'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t1_hold_addr", 78'(wb_addr), 78'd7);
    end
    put(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    tick();
    idle();
    chk("t1_empty_bundle", out_word, '0);
    chk("t1_empty_cnt", 78'(o_cnt), 78'd0);

    // Fill to 8, watch stall, then drain in order.
    for (int i = 0; i < 8; i++) begin
      put(1'b1, 1'b0, 5'(i), $urandom, $urandom, 1'b0);
      tick();
      chk("t2_stall", 78'(o_stall), (i >= 4) ? 78'd1 : 78'd0);
    end
    idle();
    chk("t2_full_cnt", 78'(o_cnt), 78'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain_addr", 78'(wb_addr), 78'(i));
      put(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
      tick();
    end
    idle();
    chk("t2_end_cnt", 78'(o_cnt), 78'd0);
    chk("t2_end_stall", 78'(o_stall), 78'd0);

    // Full + pop + push, then dropped push.
    for (int i = 0; i < 8; i++) begin
      put(1'b1, 1'b0, 5'(i), $urandom, $urandom, 1'b0);
      tick();
    end
    put(1'b0, 1'b1, 5'd9, $urandom, $urandom, 1'b1);
    tick();
    chk("t3_cnt_kept", 78'(o_cnt), 78'd8);
    chk("t3_no_ovf", 78'(o_ovf), 78'd0);
    put(1'b1, 1'b0, 5'd10, $urandom, $urandom, 1'b0);
    tick();
    chk("t3_ovf", 78'(o_ovf), 78'd1);
    chk("t3_cnt_drop", 78'(o_cnt), 78'd8);
    for (int i = 1; i <= 8; i++) begin
      chk("t3_drain_addr", 78'(wb_addr), (i == 8) ? 78'd9 : 78'(i));
      put(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
      tick();
    end
    idle();
    chk("t3_ovf_sticky", 78'(o_ovf), 78'd1);

    // Streaming push+ack with pointer wrap.
    put(1'b1, 1'b0, 5'd0, $urandom, $urandom, 1'b0);
    tick();
    for (int c = 1; c <= 20; c++) begin
      chk("t4_addr", 78'(wb_addr), 78'(c - 1));
      chk("t4_cnt", 78'(o_cnt), 78'd1);
      put(1'b1, 1'b1, 5'(c % 32), $urandom, $urandom, 1'b1);
      tick();
    end
    put(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    tick();

    // Ack while empty is ignored.
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_empty_cnt", 78'(o_cnt), 78'd0);
    end
    put(1'b1, 1'b1, 5'd12, $urandom, $urandom, 1'b1);
    tick();
    chk("t5_cnt", 78'(o_cnt), 78'd1);
    chk("t5_addr", 78'(wb_addr), 78'd12);
    put(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    tick();
    idle();
    chk("t5_consumed", 78'(o_cnt), 78'd0);

    // Asynchronous reset mid-cycle with 3 entries queued.
    for (int i = 0; i < 3; i++) begin
      put(1'b1, 1'b0, 5'(i + 20), $urandom, $urandom, 1'b0);
      tick();
    end
    idle();
    #2 rst = 1'b0;
    #1;
    chk("t6_bundle", out_word, '0);
    chk("t6_cnt", 78'(o_cnt), 78'd0);
    chk("t6_stall", 78'(o_stall), 78'd0);
    chk("t6_ovf", 78'(o_ovf), 78'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    put(1'b1, 1'b0, 5'd31, $urandom, $urandom, 1'b0);
    tick();
    idle();
    chk("t6_first_addr", 78'(wb_addr), 78'd31);

    // Randomized traffic in phases of differing push/ack pressure.
    for (int ph = 0; ph < 4; ph++) begin
      int pp, pa;
      pp = (ph % 2 == 0) ? 85 : 30;
      pa = (ph % 2 == 0) ? 30 : 80;
      for (int c = 0; c < 150; c++) begin
        i_stb0  = ($urandom_range(0, 99) < pp) ? 1'b1 : 1'b0;
        i_stb1  = 1'($urandom);
        i_enaA  = 2'($urandom);
        i_tagA  = 1'($urandom);
        i_enaB  = 2'($urandom);
        i_tagB  = 1'($urandom);
        i_modB  = 1'($urandom);
        i_addr  = 5'($urandom);
        i_dataL = $urandom;
        i_dataH = $urandom;
        wb_ack  = ($urandom_range(0, 99) < pa) ? 1'b1 : 1'b0;
        tick();
      end
    end
    idle();
    tick();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/eco32_core_fpu_wbq.md
# eco32_core_fpu_wbq

FPU write-back queue sitting directly downstream of the FPU pipeline (`eco32_core_fpu_box`) and upstream of the shared register-file write port. It captures every FPU write-back bundle in a first-word-fall-through FIFO. It presents the head bundle to the register file and holds it until the port acknowledges. Fill level is reported back to issue control so the three-stage FPU pipeline never overruns the queue.

## Interface
- `DEPTH_LOG2`, default 3: queue depth = 2^DEPTH_LOG2 entries (8).
- `STALL_MARGIN`, default 3: free entries reserved for in-flight FPU instructions.

- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_stb0`, `i_stb1`  in  1 each  write-back strobes from FPU; entry pushed when `i_stb0|i_stb1`.
- `i_enaA`  in  2  thread-A half-enables.
- `i_tagA`  in  1  thread-A tag.
- `i_enaB`  in  2  thread-B half-enables.
- `i_tagB`  in  1  thread-B tag.
- `i_modB`  in  1  thread-B mode bit.
- `i_addr`  in  5  destination register.
- `i_dataL`  in  32  low result word.
- `i_dataH`  in  32  high result word.
- `wb_stb0`, `wb_stb1`, `wb_enaA[1:0]`, `wb_tagA`, `wb_enaB[1:0]`, `wb_tagB`, `wb_modB`, `wb_addr[4:0]`, `wb_dataL[31:0]`, `wb_dataH[31:0]`  out  head-entry fields toward the register file. All zero when the queue is empty.
- `wb_ack`  in  1  register-file port accepted the presented entry this cycle.
- `o_stall`  out  1  registered; tells issue control to stop FPU issue.
- `o_cnt`  out  DEPTH_LOG2+1  current occupancy.
- `o_ovf`  out  1  sticky overflow flag.

## Operation
- Entry = 78-bit concatenation of all `i_*` fields, stored unchanged. Entries with both ena fields zero are still queued.
- `push = i_stb0|i_stb1`. `valid = (o_cnt != 0)`. `pop = valid & wb_ack`.
- Push is accepted when `o_cnt < DEPTH`, or when `pop` occurs in the same cycle (full + pop + push keeps `o_cnt = DEPTH`).
- A push while full without pop is dropped. `o_ovf` is set and stays 1 until reset. The queue contents are unchanged.
- `wb_ack` while empty is ignored. No pointer or count change.
- Pointers `wr_ptr`, `rd_ptr` are DEPTH_LOG2 bits and wrap modulo DEPTH.
- `o_cnt` update per cycle:
  - +1 on accepted push without pop.
  - −1 on pop without push.
  - Unchanged otherwise.
- `wb_*` outputs are combinational from `rd_ptr` entry, gated by `valid`. Storage may be LUT-RAM.
- The head is held stable, all fields unchanged, until the cycle `wb_ack` is high.
- `o_stall` register next value: `(o_cnt_next > DEPTH − STALL_MARGIN − 1)`, i.e. asserts when fewer than STALL_MARGIN+1 free entries remain.
- Reset (asynchronous, any time, including mid-drain):
  - Pointers, `o_cnt`, `o_stall`, `o_ovf` go to 0.
  - All `wb_*` go to 0 immediately.
  - Storage contents are don't-care.

## Timing
- Push at edge N into an empty queue: entry visible on `wb_*` after edge N (same cycle as `o_cnt = 1`). Latency is 1 clock from `i_stb*` to `wb_stb*`.
- Throughput: one push and one pop per cycle. Back-to-back acks drain one entry per clock with no bubble.
- `wb_ack` is sampled on edge E. The next entry, or zeros if the queue becomes empty, appears after E.
- `o_stall` changes on the same edge as `o_cnt`.
- Same-cycle push and pop when empty is impossible (pop needs valid). The push is accepted and `o_cnt` becomes 1.
- `o_ovf` goes high on the edge of the dropped push.

## Test plan
- Reset, then one push (addr=5'd7, dataL=32'h3F800000, dataH=0, enaA=2'b11, stb0=stb1=1) with `wb_ack=0` -> next cycle `wb_addr=7`, `wb_dataL=32'h3F800000`, `o_cnt=1`. Held 5 cycles unchanged. Assert `wb_ack` for 1 cycle -> `wb_*` all zero, `o_cnt=0`.
- 8 consecutive pushes (addr 0..7), no ack -> `o_cnt=8`, `o_stall=1` from the cycle `o_cnt` reaches 5. Then 8 cycles of ack -> `wb_addr` sequence 0..7 one per cycle, `o_cnt=0`, `o_stall=0`.
- Full queue, push addr=5'd9 with `wb_ack=1` same cycle -> `o_cnt` stays 8, `o_ovf=0`, addr 9 emerges last after draining. Next push with no ack -> dropped, `o_ovf=1` until reset.
- Continuous push+ack for 20 cycles (addr = cycle mod 32) -> `o_cnt` constant 1, every addr observed in order, pointers wrap past 7 without loss.
- `wb_ack=1` held while empty for 4 cycles, then one push -> `o_cnt` never negative/wrapped, entry visible and consumed on the following ack.
- Queue holding 3 entries, assert `rst` low mid-cycle -> all `wb_*`, `o_cnt`, `o_stall`, `o_ovf` zero immediately. After release, a first push of addr=5'd31 appears at head.
